// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Desc     : Shared types and constants for the iterative integer divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int          DIV_W      = 32;
    localparam int          DIV_ITER   = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_t;

    // Magnitude of a two's complement operand; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DIV_W-1:0] absVal(input logic [DIV_W-1:0] v);
        return v[DIV_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
// Module   : div_if
// Desc     : Pipeline-side request/response bundle of the divider.
// Revision : 1.0 - initial release
// ============================================================================
interface div_if;

    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        hold;
    logic        stall_div;
    logic        ready;
    logic [63:0] result;

    // Pipeline (request side)
    modport master (
        output start, signed_div, a, b, annul, hold,
        input  stall_div, ready, result
    );

    // Divider
    modport slave (
        input  start, signed_div, a, b, annul, hold,
        output stall_div, ready, result
    );

endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Desc     : Radix-2 restoring divider for DIV/DIVU, one quotient bit per
//            cycle. Result is {remainder, quotient} for HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit
    import div_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    div_if.slave      bus
);

    divState_t          r_state;
    divState_t          w_nextState;
    logic [5:0]         r_count;
    logic [DIV_W-1:0]   r_divisor;
    logic [2*DIV_W-1:0] r_acc;       // {partial remainder, dividend/quotient}
    logic               r_negQ;
    logic               r_negR;
    logic               r_divZero;
    logic               r_consumed;  // instruction already finished, wait for start to drop
    logic [2*DIV_W-1:0] r_result;

    logic               w_accept;
    logic               w_lastIter;
    logic [DIV_W+1:0]   w_diff;
    logic               w_fits;
    logic [2*DIV_W-1:0] w_accNext;
    logic [DIV_W-1:0]   w_quoFin;
    logic [DIV_W-1:0]   w_remFin;

    assign w_accept   = (r_state == IDLE) & bus.start & ~bus.annul & ~r_consumed;
    assign w_lastIter = (r_count == 6'(DIV_ITER - 1));

    // Trial subtraction of divisor from {remainder, next dividend bit}; the
    // top bit is the borrow.
    assign w_diff    = {1'b0, r_acc[2*DIV_W-1:DIV_W-1]} - {2'b00, r_divisor};
    assign w_fits    = ~w_diff[DIV_W+1];
    assign w_accNext = w_fits ? {w_diff[DIV_W-1:0], r_acc[DIV_W-2:0], 1'b1}
                              : {r_acc[2*DIV_W-2:0], 1'b0};

    // Sign fixup of the final iteration's outcome. With a zero divisor the
    // remainder already equals |a| and the sign fix restores a itself.
    assign w_quoFin = r_divZero ? DIV_ZERO_Q
                    : (r_negQ ? -w_accNext[DIV_W-1:0] : w_accNext[DIV_W-1:0]);
    assign w_remFin = r_negR ? -w_accNext[2*DIV_W-1:DIV_W] : w_accNext[2*DIV_W-1:DIV_W];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state logic; annul overrides every transition
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_nextState = BUSY;
            BUSY:    if (w_lastIter)  w_nextState = DONE;
            DONE:    if (!bus.hold)   w_nextState = IDLE;
            default:                  w_nextState = IDLE;
        endcase
        if (bus.annul) w_nextState = IDLE;
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_divisor <= '0;
            r_acc     <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_divZero <= 1'b0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_divisor <= bus.signed_div ? absVal(bus.b) : bus.b;
            r_acc     <= {{DIV_W{1'b0}}, (bus.signed_div ? absVal(bus.a) : bus.a)};
            r_negQ    <= bus.signed_div & (bus.a[DIV_W-1] ^ bus.b[DIV_W-1]);
            r_negR    <= bus.signed_div & bus.a[DIV_W-1];
            r_divZero <= (bus.b == '0);
        end else if ((r_state == BUSY) && !bus.annul) begin
            r_acc   <= w_accNext;
            r_count <= r_count + 6'd1;
            if (w_lastIter) r_result <= {w_remFin, w_quoFin};
        end
    end

    // Block a second run for the same instruction while start stays high
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_consumed <= 1'b0;
        else if (r_state == DONE)   r_consumed <= bus.start;
        else if (!bus.start)        r_consumed <= 1'b0;
    end

    // A consumed start does not stall, otherwise the pipeline would freeze
    // with the finished instruction stuck in E.
    assign bus.stall_div = ~bus.annul &
                           (((r_state == IDLE) & bus.start & ~r_consumed) | (r_state == BUSY));
    assign bus.ready     = (r_state == DONE) & ~bus.annul;
    assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
module tb_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    div_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Start an operation at a negedge, count stall cycles until ready (bounded).
    // Returns just after the negedge of the first ready cycle, start still high.
    task automatic runOp(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic gotReady);
        stalls   = 0;
        gotReady = 1'b0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.signed_div = sd;
        bus.a          = a;
        bus.b          = b;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.ready) begin
                gotReady = 1'b1;
                break;
            end
            if (bus.stall_div) stalls++;
            @(negedge clk);
        end
    endtask

    int          stalls;
    logic        gotReady;
    logic [63:0] lastRes;
    int          readySeen;

    initial begin
        bus.start = 0; bus.signed_div = 0; bus.a = 0; bus.b = 0;
        bus.annul = 0; bus.hold = 0;

        vecs[0]  = '{"divu_7_2",      1'b0, 32'd7,        32'd2,        {32'h1,        32'h3}};
        vecs[1]  = '{"div_m7_2",      1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
        vecs[2]  = '{"div_ovf",       1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0,        32'h80000000}};
        vecs[3]  = '{"divu_5_0",      1'b0, 32'd5,        32'd0,        {32'h5,        32'hFFFFFFFF}};
        vecs[4]  = '{"div_m5_0",      1'b1, 32'hFFFFFFFB, 32'd0,        {32'hFFFFFFFB, 32'hFFFFFFFF}};
        vecs[5]  = '{"divu_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        {32'h0,        32'hFFFFFFFF}};
        vecs[6]  = '{"div_7_m2",      1'b1, 32'd7,        32'hFFFFFFFE, {32'h1,        32'hFFFFFFFD}};
        vecs[7]  = '{"divu_100_7",    1'b0, 32'd100,      32'd7,        {32'd2,        32'd14}};
        vecs[8]  = '{"divu_3_10",     1'b0, 32'd3,        32'd10,       {32'd3,        32'd0}};
        vecs[9]  = '{"divu_max_64k",  1'b0, 32'hFFFFFFFF, 32'h00010000, {32'h0000FFFF, 32'h0000FFFF}};
        vecs[10] = '{"div_m100_m7",   1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}};

        // Reset state
        #2;
        check("rst_stall",  {63'd0, bus.stall_div}, 64'd0);
        check("rst_ready",  {63'd0, bus.ready},      64'd0);
        check("rst_result", bus.result,              64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven operations
        foreach (vecs[i]) begin
            runOp(vecs[i].sd, vecs[i].a, vecs[i].b, stalls, gotReady);
            check({vecs[i].name, "_ready"}, {63'd0, gotReady}, 64'd1);
            check({vecs[i].name, "_stalls"}, 64'(stalls), 64'd33);
            check({vecs[i].name, "_result"}, bus.result, vecs[i].exp);
            bus.start = 1'b0;
            @(negedge clk); #1;
            check({vecs[i].name, "_idle_ready"}, {63'd0, bus.ready}, 64'd0);
            check({vecs[i].name, "_idle_hold"}, bus.result, vecs[i].exp);
        end
        lastRes = vecs[10].exp;

        // Annul in BUSY cycle 10
        @(negedge clk);
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd7; bus.b = 32'd2;
        for (int c = 0; c < 10; c++) @(negedge clk);
        bus.annul = 1'b1;
        #1;
        check("annul_stall", {63'd0, bus.stall_div}, 64'd0);
        check("annul_ready", {63'd0, bus.ready},     64'd0);
        @(negedge clk);
        bus.annul = 1'b0; bus.start = 1'b0;
        #1;
        check("annul_idle_stall", {63'd0, bus.stall_div}, 64'd0);
        check("annul_result_kept", bus.result, lastRes);
        runOp(1'b0, 32'd100, 32'd7, stalls, gotReady);
        check("post_annul_ready",  {63'd0, gotReady}, 64'd1);
        check("post_annul_stalls", 64'(stalls), 64'd33);
        check("post_annul_result", bus.result, {32'd2, 32'd14});
        bus.start = 1'b0;
        @(negedge clk);

        // Hold at DONE with start held, then release: no restart
        runOp(1'b0, 32'd12, 32'd5, stalls, gotReady);
        check("hold_first_ready", {63'd0, gotReady}, 64'd1);
        check("hold_first_result", bus.result, {32'd2, 32'd2});
        bus.hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("hold_ready",  {63'd0, bus.ready}, 64'd1);
            check("hold_result", bus.result, {32'd2, 32'd2});
        end
        @(negedge clk);
        bus.hold = 1'b0;
        #1;
        check("hold_last_ready", {63'd0, bus.ready}, 64'd1);
        @(negedge clk); #1;
        check("hold_rel_ready", {63'd0, bus.ready}, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        readySeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (bus.ready) readySeen++;
        end
        check("no_restart", 64'(readySeen), 64'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd7; bus.b = 32'd2;
        for (int c = 0; c < 20; c++) @(negedge clk);
        #1;
        check("mid_stall_before_rst", {63'd0, bus.stall_div}, 64'd1);
        rst = 1'b1; bus.start = 1'b0;
        #1;
        check("rst_mid_stall",  {63'd0, bus.stall_div}, 64'd0);
        check("rst_mid_ready",  {63'd0, bus.ready},      64'd0);
        check("rst_mid_result", bus.result,              64'd0);
        @(negedge clk);
        rst = 1'b0;
        runOp(1'b0, 32'd9, 32'd3, stalls, gotReady);
        check("post_rst_ready",  {63'd0, gotReady}, 64'd1);
        check("post_rst_stalls", 64'(stalls), 64'd33);
        check("post_rst_result", bus.result, {32'd0, 32'd3});
        bus.start = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Clock/reset: one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  E-stage instruction is DIV/DIVU; held high while the instruction stays in E.
REQ-005 signed_div  input  1  1 = DIV (two's complement); 0 = DIVU; sampled with operands.
REQ-006 a  input  32  dividend (rs value after E-stage forwarding).
REQ-007 b  input  32  divisor (rt value after E-stage forwarding).
REQ-008 annul  input  1  flushE / exception kill; aborts any operation.
REQ-009 hold  input  1  external pipeline freeze (i_stall | d_stall); keeps DONE result alive.
REQ-010 stall_div  output  1  drives stall_divE: freeze F/D/E/M/W while dividing.
REQ-011 ready  output  1  result valid this cycle.
REQ-012 result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.

Function
REQ-013 States: IDLE, BUSY, DONE; 6-bit iteration counter; radix-2 restoring division, one quotient bit per cycle.
REQ-014 IDLE & start & ~annul: latch |a|, |b| (signed_div) or a, b raw, plus sign flags; counter=0; next BUSY.
REQ-015 BUSY: one iteration per cycle; after 32nd iteration (counter==31) next DONE.
REQ-016 Latency: start accepted in cycle 0, DONE in cycle 33; stall_div high cycles 0..32 (33 cycles).
REQ-017 stall_div = ~annul & ((IDLE & start) | BUSY), combinational; low in DONE.
REQ-018 DONE: ready=1, result stable; stay in DONE while hold=1; go to IDLE when hold=0.
REQ-019 start still high in DONE or on the IDLE cycle directly after DONE shall not restart (one-cycle "consumed" flag cleared when start falls).
REQ-020 Signed fixup: quotient negated iff sign(a)!=sign(b); remainder takes sign of a.
REQ-021 0x80000000 / 0xFFFFFFFF signed: q=0x80000000, r=0 (wraps; no trap).
REQ-022 Divide by zero (b==0): normal 33-cycle latency; result = {a, 32'hFFFFFFFF}; no exception raised.
REQ-023 annul in any state: next state IDLE, ready=0, stall_div=0 same cycle; annul has priority over start.
REQ-024 Outside DONE: ready=0, result holds last completed value.

Reset
REQ-025 rst asserted: state=IDLE, counter=0, consumed flag=0, stall_div=0, ready=0, result=0, internal registers 0.
REQ-026 rst mid-operation aborts it; first start after release begins a full 33-cycle operation.

Structure
REQ-027 Shared package div_pkg: state enum {IDLE, BUSY, DONE}, DIV_W=32, DIV_ITER=32, DIV_ZERO_Q=32'hFFFFFFFF.
REQ-028 No sub-module; single module, 64-bit partial remainder/quotient shift register plus 33-bit subtractor.

Verification
REQ-029 DIVU 7/2: stall_div high 33 cycles, then ready=1, result={32'h1, 32'h3}.
REQ-030 DIV -7/2: result={32'hFFFFFFFF, 32'hFFFFFFFD}; DIV 0x80000000/0xFFFFFFFF: result={0, 32'h80000000}.
REQ-031 DIVU 5/0: after 33 cycles result={32'h5, 32'hFFFFFFFF}, no hang.
REQ-032 annul at cycle 10 of BUSY: stall_div=0 same cycle, IDLE next; new start 100/7 gives {2, 14} after 33 cycles.
REQ-033 hold=1 for 5 cycles at DONE with start held: ready and result stable, no restart; hold=0 then start=0 -> IDLE.
REQ-034 rst pulse at cycle 20: all outputs 0 immediately, state IDLE; subsequent DIVU 9/3 gives {0, 3}.
